// File: rtl/bip_control_if.sv
// Control-unit bus for the BIP core: instruction fetch, data-memory strobes
// and datapath control. master = control unit, slave = memories/datapath side.
interface bip_control_if #(
  parameter int OPC_W  = 5,
  parameter int DATA_W = 11,
  parameter int PC_W   = 11,
  parameter int CNT_W  = 32
);
  logic                    run_i;
  logic [OPC_W+DATA_W-1:0] instr_i;
  logic [PC_W-1:0]         imem_addr_o;
  logic [DATA_W-1:0]       dmem_addr_o;
  logic                    dmem_rd_o;
  logic                    dmem_wr_o;
  logic [DATA_W-1:0]       operand_o;
  logic [1:0]              sel_a_o;
  logic                    sel_b_o;
  logic                    alu_op_o;
  logic                    acc_we_o;
  logic                    halted_o;
  logic [CNT_W-1:0]        cycle_cnt_o;

  modport master (
    input  run_i, instr_i,
    output imem_addr_o, dmem_addr_o, dmem_rd_o, dmem_wr_o, operand_o,
           sel_a_o, sel_b_o, alu_op_o, acc_we_o, halted_o, cycle_cnt_o
  );

  modport slave (
    output run_i, instr_i,
    input  imem_addr_o, dmem_addr_o, dmem_rd_o, dmem_wr_o, operand_o,
           sel_a_o, sel_b_o, alu_op_o, acc_we_o, halted_o, cycle_cnt_o
  );
endinterface

// File: rtl/bip_control.sv
// BIP multi-cycle control unit: FETCH -> DECODE -> EXEC -> WB per instruction,
// HLT parks the core in HALT until reset. Drives PC, dmem strobes, ACC/ALU selects.
module bip_control #(
  parameter int OPC_W  = 5,
  parameter int DATA_W = 11,
  parameter int PC_W   = 11,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              rst,
  bip_control_if.master    bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

  state_t                  r_state;
  state_t                  w_next;
  logic [PC_W-1:0]         r_pc;
  logic [OPC_W+DATA_W-1:0] r_ir;
  logic [CNT_W-1:0]        r_cnt;

  logic [OPC_W-1:0] w_opc;
  logic [OPC_W-1:0] w_fetch_opc;
  logic             w_cnt_en;
  logic             w_is_sto, w_is_ld, w_is_ldi, w_is_add, w_is_addi, w_is_sub, w_is_subi;
  logic             w_arith;

  assign w_opc       = r_ir[OPC_W+DATA_W-1 -: OPC_W];
  assign w_fetch_opc = bus.instr_i[OPC_W+DATA_W-1 -: OPC_W];

  assign w_is_sto  = (w_opc == OP_STO);
  assign w_is_ld   = (w_opc == OP_LD);
  assign w_is_ldi  = (w_opc == OP_LDI);
  assign w_is_add  = (w_opc == OP_ADD);
  assign w_is_addi = (w_opc == OP_ADDI);
  assign w_is_sub  = (w_opc == OP_SUB);
  assign w_is_subi = (w_opc == OP_SUBI);
  assign w_arith   = w_is_add | w_is_addi | w_is_sub | w_is_subi;

  // Cycles spent halted or stalled waiting for run_i are not counted
  assign w_cnt_en = (r_state != S_HALT) && !((r_state == S_FETCH) && !bus.run_i);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // PC, instruction register and saturating cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == S_DECODE) r_ir <= bus.instr_i;
      if (r_state == S_WB)     r_pc <= r_pc + 1'b1;
      if (w_cnt_en && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Next-state logic and Moore output decode from state + IR
  always_comb begin
    w_next        = r_state;
    bus.dmem_rd_o = 1'b0;
    bus.dmem_wr_o = 1'b0;
    bus.sel_a_o   = 2'b00;
    bus.sel_b_o   = 1'b0;
    bus.alu_op_o  = 1'b0;
    bus.acc_we_o  = 1'b0;
    bus.halted_o  = 1'b0;

    // Selects are held over EXEC and WB so the datapath sees them settled before the ACC write
    if ((r_state == S_EXEC) || (r_state == S_WB)) begin
      bus.sel_a_o  = w_arith ? 2'b10 : (w_is_ldi ? 2'b01 : 2'b00);
      bus.sel_b_o  = w_is_addi | w_is_subi;
      bus.alu_op_o = w_is_add | w_is_addi;
    end

    case (r_state)
      S_FETCH:  if (bus.run_i) w_next = S_DECODE;
      S_DECODE: w_next = (w_fetch_opc == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        bus.dmem_rd_o = w_is_ld | w_is_add | w_is_sub;
        bus.dmem_wr_o = w_is_sto;
        w_next        = S_WB;
      end
      S_WB: begin
        bus.acc_we_o = w_is_ld | w_is_ldi | w_arith;
        w_next       = S_FETCH;
      end
      S_HALT:   bus.halted_o = 1'b1;
      default:  w_next = S_FETCH;
    endcase
  end

  assign bus.imem_addr_o = r_pc;
  assign bus.dmem_addr_o = r_ir[DATA_W-1:0];
  assign bus.operand_o   = r_ir[DATA_W-1:0];
  assign bus.cycle_cnt_o = r_cnt;

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: small programs in a synchronous imem
// model, strobe events checked against a queue of expected events.
module tb_bip_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bip_control_if #(.OPC_W(5), .DATA_W(11), .PC_W(11), .CNT_W(32)) bus ();
  bip_control_if #(.OPC_W(5), .DATA_W(11), .PC_W(11), .CNT_W(4))  bus2 ();

  bip_control #(.OPC_W(5), .DATA_W(11), .PC_W(11), .CNT_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bip_control #(.OPC_W(5), .DATA_W(11), .PC_W(11), .CNT_W(4)) u_dut_c4 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic [15:0] imem [2048];

  // Synchronous instruction memory, one read port per DUT
  always @(posedge clk) begin
    bus.instr_i  <= imem[bus.imem_addr_o];
    bus2.instr_i <= imem[bus2.imem_addr_o];
  end
  assign bus2.run_i = bus.run_i;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Cycle index since reset release: cycle 0 is the first FETCH
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [2:0]  strb;     // {dmem_rd, dmem_wr, acc_we}
    logic [10:0] addr;
    logic [1:0]  sel_a;
    logic        chk_alu;
    logic        sel_b;
    logic        alu_op;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [10:0] arg);
    return {op, arg};
  endfunction

  function automatic ev_t ev(input int c, input logic [2:0] s, input logic [10:0] a,
                             input logic [1:0] sa, input logic ca, input logic sbv,
                             input logic op);
    ev_t e;
    e.cyc = c; e.strb = s; e.addr = a; e.sel_a = sa; e.chk_alu = ca; e.sel_b = sbv; e.alu_op = op;
    return e;
  endfunction

  // Every strobe the DUT raises must match the next expected event
  always @(negedge clk) begin
    if (!rst && (bus.dmem_rd_o || bus.dmem_wr_o || bus.acc_we_o)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_strobe", {29'd0, bus.dmem_rd_o, bus.dmem_wr_o, bus.acc_we_o}, 32'd0);
      end else begin
        mon_ev = sb.pop_front();
        check_eq("ev_cycle", cyc, mon_ev.cyc);
        check_eq("ev_strobes", {29'd0, bus.dmem_rd_o, bus.dmem_wr_o, bus.acc_we_o},
                 {29'd0, mon_ev.strb});
        if (mon_ev.strb[2] || mon_ev.strb[1])
          check_eq("ev_dmem_addr", {21'd0, bus.dmem_addr_o}, {21'd0, mon_ev.addr});
        if (mon_ev.strb[0])
          check_eq("ev_sel_a", {30'd0, bus.sel_a_o}, {30'd0, mon_ev.sel_a});
        if (mon_ev.chk_alu) begin
          check_eq("ev_sel_b", {31'd0, bus.sel_b_o}, {31'd0, mon_ev.sel_b});
          check_eq("ev_alu_op", {31'd0, bus.alu_op_o}, {31'd0, mon_ev.alu_op});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((cyc != n) && (g < 20000));
    if (g >= 20000) check_eq("wait_timeout", cyc, n);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) imem[i] = mk(5'b11111, 11'(i));
  endtask

  task automatic do_reset(input logic run_val);
    rst = 1'b1;
    bus.run_i = run_val;
    @(posedge clk); #1;
    check_eq("rst_imem_addr", {21'd0, bus.imem_addr_o}, 32'd0);
    check_eq("rst_strobes_halt",
             {28'd0, bus.dmem_rd_o, bus.dmem_wr_o, bus.acc_we_o, bus.halted_o}, 32'd0);
    check_eq("rst_cycle_cnt", bus.cycle_cnt_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic end_test(input string tag);
    #1;
    check_eq(tag, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    bus.run_i = 1'b0;

    // Program A: LDI 5; ADDI 3; STO 7; HLT
    fill_nop();
    imem[0] = mk(5'b00011, 11'd5);
    imem[1] = mk(5'b00101, 11'd3);
    imem[2] = mk(5'b00001, 11'd7);
    imem[3] = mk(5'b00000, 11'd0);
    sb.push_back(ev(3,  3'b001, 11'd0, 2'b01, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(7,  3'b001, 11'd0, 2'b10, 1'b1, 1'b1, 1'b1));
    sb.push_back(ev(10, 3'b010, 11'd7, 2'b00, 1'b0, 1'b0, 1'b0));
    do_reset(1'b1);
    wait_cyc(13);
    check_eq("a_not_halted_c13", {31'd0, bus.halted_o}, 32'd0);
    wait_cyc(14);
    check_eq("a_halted_c14", {31'd0, bus.halted_o}, 32'd1);
    check_eq("a_pc_c14", {21'd0, bus.imem_addr_o}, 32'd3);
    check_eq("a_cnt_c14", bus.cycle_cnt_o, 32'd14);
    wait_cyc(20);
    check_eq("a_halted_c20", {31'd0, bus.halted_o}, 32'd1);
    check_eq("a_pc_c20", {21'd0, bus.imem_addr_o}, 32'd3);
    check_eq("a_cnt_frozen", bus.cycle_cnt_o, 32'd14);
    end_test("a_sb_empty");

    // Program B: LD 4; SUB 5; HLT
    fill_nop();
    imem[0] = mk(5'b00010, 11'd4);
    imem[1] = mk(5'b00110, 11'd5);
    imem[2] = mk(5'b00000, 11'd0);
    sb.push_back(ev(2, 3'b100, 11'd4, 2'b00, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(3, 3'b001, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(6, 3'b100, 11'd5, 2'b00, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(7, 3'b001, 11'd0, 2'b10, 1'b1, 1'b0, 1'b0));
    do_reset(1'b1);
    wait_cyc(10);
    check_eq("b_halted", {31'd0, bus.halted_o}, 32'd1);
    check_eq("b_pc", {21'd0, bus.imem_addr_o}, 32'd2);
    end_test("b_sb_empty");

    // Same program with run_i held low for 10 cycles, then raised
    sb.push_back(ev(12, 3'b100, 11'd4, 2'b00, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(13, 3'b001, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(16, 3'b100, 11'd5, 2'b00, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(17, 3'b001, 11'd0, 2'b10, 1'b1, 1'b0, 1'b0));
    do_reset(1'b0);
    wait_cyc(10);
    check_eq("stall_pc", {21'd0, bus.imem_addr_o}, 32'd0);
    check_eq("stall_cnt", bus.cycle_cnt_o, 32'd0);
    bus.run_i = 1'b1;
    wait_cyc(11);
    check_eq("stall_cnt_after_run", bus.cycle_cnt_o, 32'd1);
    wait_cyc(20);
    check_eq("stall_halted", {31'd0, bus.halted_o}, 32'd1);
    end_test("stall_sb_empty");

    // Reset asserted in the middle of STO's EXEC cycle
    fill_nop();
    imem[0] = mk(5'b00001, 11'd9);
    imem[1] = mk(5'b00000, 11'd0);
    sb.push_back(ev(2, 3'b010, 11'd9, 2'b00, 1'b0, 1'b0, 1'b0));
    do_reset(1'b1);
    wait_cyc(2);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_wr_low", {31'd0, bus.dmem_wr_o}, 32'd0);
    check_eq("midrst_pc", {21'd0, bus.imem_addr_o}, 32'd0);
    check_eq("midrst_sb_empty", sb.size(), 32'd0);
    sb.push_back(ev(2, 3'b010, 11'd9, 2'b00, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cyc(0);
    check_eq("midrst_restart_pc", {21'd0, bus.imem_addr_o}, 32'd0);
    wait_cyc(6);
    check_eq("midrst_halted", {31'd0, bus.halted_o}, 32'd1);
    check_eq("midrst_halt_pc", {21'd0, bus.imem_addr_o}, 32'd1);
    end_test("midrst_sb_empty_end");

    // 2048 NOPs: PC wraps, no strobes; narrow counter saturates
    fill_nop();
    do_reset(1'b1);
    wait_cyc(14);
    check_eq("c4_cnt_14", {28'd0, bus2.cycle_cnt_o}, 32'd14);
    wait_cyc(15);
    check_eq("c4_cnt_15", {28'd0, bus2.cycle_cnt_o}, 32'd15);
    wait_cyc(16);
    check_eq("c4_cnt_hold", {28'd0, bus2.cycle_cnt_o}, 32'd15);
    wait_cyc(8191);
    check_eq("nop_pc_last", {21'd0, bus.imem_addr_o}, 32'd2047);
    wait_cyc(8192);
    check_eq("nop_pc_wrap", {21'd0, bus.imem_addr_o}, 32'd0);
    check_eq("nop_cnt", bus.cycle_cnt_o, 32'd8192);
    check_eq("c4_cnt_sat", {28'd0, bus2.cycle_cnt_o}, 32'd15);
    check_eq("nop_not_halted", {31'd0, bus.halted_o}, 32'd0);
    end_test("nop_sb_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
